// File: rtl/hack_fetch_pkg.sv
// hack_fetch_pkg
//   Shared definitions for the instruction-fetch unit.
//   - HF_ADDR_W / HF_DATA_W : default address and instruction widths
//   - fetch_state_e         : fetch FSM encoding (IDLE, WAIT, DRAIN)
//   - fetch_entry_t         : prefetch queue entry layout {addr, data} at the
//                             default widths; the queue stores entries packed
//                             in this same order at any width.
package hack_fetch_pkg;

  localparam int HF_ADDR_W = 16;
  localparam int HF_DATA_W = 16;

  // IDLE  : no read outstanding
  // WAIT  : read outstanding, response will be queued
  // DRAIN : read outstanding, response will be discarded (redirect hit it)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [HF_ADDR_W-1:0] addr;
    logic [HF_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/hack_fetch_if.sv
// hack_fetch_if
//   Bundles the fetch unit's three channels:
//   - redirect channel : redirect, redirect_addr
//   - CPU channel      : instr_valid, instr_ready, instr, instr_addr
//   - ROM channel      : mem_req, mem_addr, mem_ack, mem_rdata
//   master : the fetch unit side
//   slave  : the CPU / ROM / branch environment side
interface hack_fetch_if
  import hack_fetch_pkg::*;
#(
  parameter int ADDR_W = HF_ADDR_W,
  parameter int DATA_W = HF_DATA_W
);

  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  redirect, redirect_addr, instr_ready, mem_ack, mem_rdata,
    output instr_valid, instr, instr_addr, mem_req, mem_addr
  );

  modport slave (
    output redirect, redirect_addr, instr_ready, mem_ack, mem_rdata,
    input  instr_valid, instr, instr_addr, mem_req, mem_addr
  );

endinterface

// File: rtl/hack_fetch_queue.sv
// hack_fetch_queue
//   Synchronous FIFO holding prefetched {addr, data} entries.
//   Ports:
//     clock, reset : clock and asynchronous active-high reset
//     push         : write push_data at the tail
//     pop          : drop the head entry
//     flush        : empty the queue; overrides push and pop
//     push_data    : entry to write
//     count        : number of valid entries (0..DEPTH)
//     head         : oldest entry, all zeros while empty
//   The caller guarantees no push when full and no pop when empty.
module hack_fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do. The
  // head is gated to zero while empty so stale contents never leak out.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit
//   Instruction-fetch reader: tracks its own fetch address, issues single
//   outstanding req/ack reads to instruction ROM, prefetches sequential words
//   into a small queue and hands them to the CPU over valid/ready. A redirect
//   flushes the queue and restarts fetching at redirect_addr.
//   Ports:
//     clock, reset : clock and asynchronous active-high reset
//     bus          : hack_fetch_if.master (redirect, CPU and ROM channels)
//   A request is only issued when count + in_flight < DEPTH, so a response
//   always has a free queue slot and a push never stalls.
module hack_fetch_unit
  import hack_fetch_pkg::*;
#(
  parameter int ADDR_W = HF_ADDR_W,
  parameter int DATA_W = HF_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic       clock,
  input  logic       reset,
  hack_fetch_if.master bus
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e               state;
  fetch_state_e               state_next;
  logic [ADDR_W-1:0]          fetch_addr;
  logic [ADDR_W-1:0]          fetch_addr_next;
  logic [ADDR_W-1:0]          fetch_addr_inc;
  logic                       mem_req_q;
  logic                       mem_req_next;
  logic [ADDR_W-1:0]          mem_addr_q;
  logic [ADDR_W-1:0]          mem_addr_next;
  logic                       ack;
  logic                       push;
  logic                       pop;
  logic                       issue;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       space_next;
  logic [ADDR_W+DATA_W-1:0]   head;

  // An ack only counts while a request is actually outstanding.
  assign ack            = mem_req_q & bus.mem_ack;
  assign pop            = bus.instr_valid & bus.instr_ready;
  assign push           = (state == WAIT) & ack & ~bus.redirect;
  assign fetch_addr_inc = fetch_addr + ADDR_W'(1);

  // Queue occupancy after this edge; the outstanding read (if any) resolves
  // this cycle whenever a new issue is considered, so only count matters.
  assign count_next = bus.redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign space_next = count_next < DEPTH_C;

  hack_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect),
    .push_data ({fetch_addr, bus.mem_rdata}),
    .count     (count),
    .head      (head)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr_addr  = head[ADDR_W+DATA_W-1 -: ADDR_W];
  assign bus.instr       = head[DATA_W-1:0];
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_addr <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      mem_req_q  <= mem_req_next;
      mem_addr_q <= mem_addr_next;
    end
  end

  // NOTE: combinational blocks assign a default before any branch so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (!bus.redirect && space_next) state_next = WAIT;
      WAIT:  if (ack) state_next = (!bus.redirect && space_next) ? WAIT : IDLE;
             else if (bus.redirect) state_next = DRAIN;
      DRAIN: if (ack) state_next = (!bus.redirect && space_next) ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh request starts when WAIT is entered from IDLE or when the current
  // read completes and another follows back-to-back. Issues never coincide
  // with a redirect, so the new address is simply the next fetch address.
  always_comb begin
    fetch_addr_next = fetch_addr;
    if (bus.redirect)  fetch_addr_next = bus.redirect_addr;
    else if (push)     fetch_addr_next = fetch_addr_inc;
    issue         = (state_next == WAIT) && ((state == IDLE) || ack);
    mem_req_next  = (state_next != IDLE);
    mem_addr_next = issue ? fetch_addr_next : mem_addr_q;
  end

endmodule

// File: doc/hack_fetch_unit.md
Name: hack_fetch_unit

Overview:
Instruction-fetch reader that consumes the program-counter address stream and supplies instructions to the CPU.
- Tracks its own fetch address, which mirrors the program counter's reset/load/increment behaviour.
- Issues one-outstanding req/ack reads to instruction ROM and prefetches sequential words into a small queue.
- Presents instructions to the CPU over a valid/ready handshake.
- A redirect (jump) flushes the queue and restarts fetching at a new address.

Parameters:
ADDR_W, 16, fetch/instruction address width
DATA_W, 16, instruction word width
DEPTH, 2, prefetch queue entries (power of 2, >=2)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
redirect  in  1  jump taken; restart fetch at redirect_addr
redirect_addr  in  ADDR_W  new fetch address
instr_valid  out  1  queue head valid
instr_ready  in  1  CPU accepts head this cycle
instr  out  DATA_W  head instruction word
instr_addr  out  ADDR_W  address of head instruction
mem_req  out  1  ROM read request (registered)
mem_addr  out  ADDR_W  ROM read address (registered, stable while mem_req=1)
mem_ack  in  1  ROM read complete; mem_rdata valid this cycle
mem_rdata  in  DATA_W  ROM read data

Behaviour:
- Reset (async, any time, including mid-read):
  - fetch_addr=0, queue empty, in_flight=0, drop=0, state IDLE.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_addr=0.
- Memory protocol:
  - mem_req stays high with mem_addr constant until mem_ack is sampled high.
  - A request is never withdrawn before its ack.
  - mem_ack may arrive in the same cycle mem_req first rises (0-wait).
  - mem_ack while mem_req=0 is ignored.
- Space rule: a request is issued only if count + in_flight < DEPTH. Queue therefore never overflows and a push never stalls.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: if space and !redirect -> WAIT; mem_req=1, mem_addr=fetch_addr next cycle.
  - WAIT, mem_ack=1, redirect=0:
    - Push {fetch_addr, mem_rdata}.
    - fetch_addr <= fetch_addr+1, wrapping 0xFFFF->0x0000 (mod 2^ADDR_W).
    - If space remains after this cycle's push/pop: stay WAIT, new mem_addr=fetch_addr+1, mem_req held 1 (back-to-back).
    - Otherwise: mem_req=0 -> IDLE.
  - WAIT, mem_ack=0, redirect=1: -> DRAIN; mem_req held 1.
  - DRAIN, mem_ack=1: response discarded; -> IDLE (or directly reissue at fetch_addr if space).
- Redirect (any state, sampled at edge):
  - Queue flushed (count=0) and fetch_addr <= redirect_addr.
  - instr_valid=0 the following cycle.
  - A pop in the same cycle counts as accepted by the CPU; flush wins on queue state.
  - redirect with mem_ack in the same cycle: the data is dropped and the next request goes to redirect_addr.
  - redirect while in DRAIN: fetch_addr is updated again; DRAIN continues.
- Output side:
  - instr_valid = (count != 0).
  - instr/instr_addr = queue head, held stable while valid and !ready.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are both performed.
- Latency:
  - First mem_req: one cycle after reset release.
  - Data: instr_valid rises the cycle after the accepting mem_ack.
  - Redirect: redirect edge to first new instr_valid is at least 2 cycles with 0-wait ROM, plus the remaining latency of any in-flight read.

Decomposition:
- Package hack_fetch_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding: IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - Queue-entry layout {addr, data}.
- Sub-module hack_fetch_queue: synchronous FIFO of DEPTH entries with push, pop, flush (flush priority), count, and head outputs. It uses the same asynchronous active-high reset.

Test Plan:
- Reset, 0-wait ROM (ack when req, rdata=addr^16'hA5A5), ready=1 -> instr_addr 0,1,2,3... one per cycle in steady state; instr[0]=16'hA5A5.
- instr_ready=0 for 10 cycles, ROM 0-wait -> exactly DEPTH=2 words queued (addr 0,1); mem_req=0 until a pop; head stable.
- Redirect to 16'h0100 while a 3-cycle ROM read at addr 5 is pending -> mem_req stays high until ack; addr-5 data never appears; next instr_addr=16'h0100.
- redirect_addr=16'hFFFF, ready=1 -> instr_addr sequence FFFF, 0000, 0001.
- Redirect in the same cycle as mem_ack and a CPU pop -> queue empty next cycle, instr_valid=0; the following fetch goes to redirect_addr.
- reset asserted mid-WAIT (no clock edge) -> mem_req and instr_valid drop immediately; after release, fetch restarts at addr 0.
